// File: rtl/execute_stage_md_pkg.sv
// Shared encodings for the execute stage: ALU ops, M-extension funct3,
// forwarding selects, store formatting and the multiply/divide FSM states.
package execute_stage_md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_ZERO = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_SB   = 2'b00,
        ST_SH   = 2'b01,
        ST_SW   = 2'b10,
        ST_ZERO = 2'b11
    } store_src_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // funct3 bit 2 separates the divide family from the multiply family
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/execute_stage_md_muldiv_iter.sv
// Iterative RV32M/RV64M unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up applied combinationally once in DONE.
module muldiv_iter
    import execute_stage_md_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic            i_hold,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN);

    md_state_e         r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi;     // product high half / partial remainder
    logic [XLEN-1:0]   r_lo;     // multiplier bits / dividend bits -> quotient
    logic [XLEN-1:0]   r_b;      // multiplicand / divisor magnitude
    logic [2:0]        r_op;
    logic              r_neg_q;  // negate product or quotient
    logic              r_neg_r;  // negate remainder (sign of dividend)
    logic              r_dz;     // divide by zero: quotient forced to all-ones

    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_quo, w_rem;

    // Operand signedness and magnitudes at capture time
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
        case (md_op_e'(i_op))
            MD_MULH, MD_DIV, MD_REM: begin
                w_a_neg = i_a[XLEN-1];
                w_b_neg = i_b[XLEN-1];
            end
            MD_MULHSU: w_a_neg = i_a[XLEN-1];
            default: ;
        endcase
        w_a_mag = w_a_neg ? -i_a : i_a;
        w_b_mag = w_b_neg ? -i_b : i_b;
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_ge    = w_div_shift >= {1'b0, r_b};
        w_div_sub   = w_div_shift[XLEN-1:0] - r_b;
    end

    // Sign correction and result selection, valid while in DONE
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = r_neg_q ? -w_prod : w_prod;
        w_quo    = r_dz ? '1 : (r_neg_q ? -r_lo : r_lo);
        w_rem    = r_neg_r ? -r_hi : r_hi;
        case (md_op_e'(r_op))
            MD_MUL:                       o_result = w_prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              o_result = w_quo;
            default:                      o_result = w_rem;
        endcase
    end

    // Control FSM with iteration counter and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_lo    <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_op    <= i_op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dz    <= md_is_div(i_op) && (i_b == '0);
                    end
                end
                MD_BUSY: begin
                    if (i_kill) begin
                        r_state <= MD_IDLE;
                    end else begin
                        if (md_is_div(r_op)) begin
                            r_hi <= w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], w_div_ge};
                        end else begin
                            {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) r_state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (i_kill || !i_hold) r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != MD_IDLE);
    assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: forwarding, ALU, branch target, store formatting, the
// iterative M unit and the EX/MEM pipeline register with valid tracking.
module execute_stage_md
    import execute_stage_md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit MD_EN = 1'b1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_id_valid,
    input  logic [XLEN-1:0] i_rd1,
    input  logic [XLEN-1:0] i_rd2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_imm,
    input  logic [3:0]      i_alu_ctrl,
    input  logic            i_alu_src,
    input  logic            i_md_en,
    input  logic [2:0]      i_md_op,
    input  logic [1:0]      i_store_src,
    input  logic [1:0]      i_fwd_a_sel,
    input  logic [1:0]      i_fwd_b_sel,
    input  logic [XLEN-1:0] i_fwd_mem,
    input  logic [XLEN-1:0] i_fwd_wb,
    input  logic [4:0]      i_rd_in,
    input  logic            i_reg_write_in,
    input  logic            i_mem_write_in,
    input  logic [2:0]      i_result_src_in,
    input  logic            i_mem_stall,
    input  logic            i_md_kill,
    output logic            o_ex_stall,
    output logic            o_md_busy,
    output logic [XLEN-1:0] o_pc_target,
    output logic [XLEN-1:0] o_ex_result_m,
    output logic [XLEN-1:0] o_mem_wdata_m,
    output logic [XLEN-1:0] o_pc_m,
    output logic [XLEN-1:0] o_pc_plus4_m,
    output logic [4:0]      o_rd_m,
    output logic            o_reg_write_m,
    output logic            o_mem_write_m,
    output logic            o_valid_m,
    output logic [2:0]      o_result_src_m
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu_y, w_store;
    logic [XLEN-1:0] w_md_result, w_ex_result;
    logic            w_md_req, w_md_busy, w_md_done, w_kill;

    logic [XLEN-1:0] r_ex_result, r_mem_wdata, r_pc, r_pc_plus4;
    logic [4:0]      r_rd;
    logic            r_reg_write, r_mem_write, r_valid;
    logic [2:0]      r_result_src;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [XLEN-1:0] reg_v,
                                                input logic [XLEN-1:0] mem_v,
                                                input logic [XLEN-1:0] wb_v);
        case (fwd_sel_e'(sel))
            FWD_REG: return reg_v;
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return '0;
        endcase
    endfunction

    // Forwarding muxes, then the immediate select on the B operand
    always_comb begin
        w_src_a = fwd_mux(i_fwd_a_sel, i_rd1, i_fwd_mem, i_fwd_wb);
        w_fwd_b = fwd_mux(i_fwd_b_sel, i_rd2, i_fwd_mem, i_fwd_wb);
        w_src_b = i_alu_src ? i_imm : w_fwd_b;
    end

    // Single-cycle ALU
    always_comb begin
        case (alu_ctrl_e'(i_alu_ctrl))
            ALU_ADD:   w_alu_y = w_src_a + w_src_b;
            ALU_SUB:   w_alu_y = w_src_a - w_src_b;
            ALU_AND:   w_alu_y = w_src_a & w_src_b;
            ALU_OR:    w_alu_y = w_src_a | w_src_b;
            ALU_XOR:   w_alu_y = w_src_a ^ w_src_b;
            ALU_SLT:   w_alu_y = XLEN'($signed(w_src_a) < $signed(w_src_b));
            ALU_SLTU:  w_alu_y = XLEN'(w_src_a < w_src_b);
            ALU_SLL:   w_alu_y = w_src_a << w_src_b[SHW-1:0];
            ALU_SRL:   w_alu_y = w_src_a >> w_src_b[SHW-1:0];
            ALU_SRA:   w_alu_y = $unsigned($signed(w_src_a) >>> w_src_b[SHW-1:0]);
            ALU_PASSB: w_alu_y = w_src_b;
            default:   w_alu_y = '0;
        endcase
    end

    // Store data comes from forwarded B, ahead of the immediate mux
    always_comb begin
        case (store_src_e'(i_store_src))
            ST_SB:   w_store = XLEN'($signed(w_fwd_b[7:0]));
            ST_SH:   w_store = XLEN'($signed(w_fwd_b[15:0]));
            ST_SW:   w_store = XLEN'($signed(w_fwd_b[31:0]));
            default: w_store = '0;
        endcase
    end

    assign o_pc_target = i_pc + i_imm;

    // The M unit only sees requests when the extension is built in
    assign w_md_req = i_id_valid & i_md_en & MD_EN;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_md_req),
        .i_kill   (i_md_kill),
        .i_hold   (i_mem_stall),
        .i_op     (i_md_op),
        .i_a      (w_src_a),
        .i_b      (w_fwd_b),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );

    assign o_ex_stall  = i_mem_stall | (w_md_req & ~w_md_done);
    assign o_md_busy   = w_md_busy;
    assign w_ex_result = (w_md_req & w_md_done) ? w_md_result : w_alu_y;
    // A killed M op must never reach writeback, even from DONE
    assign w_kill      = i_md_kill & w_md_busy;

    // EX/MEM register: hold on memory stall, bubble on EX stall or kill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_result  <= '0;
            r_mem_wdata  <= '0;
            r_pc         <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_valid      <= 1'b0;
            r_result_src <= '0;
        end else if (!i_mem_stall) begin
            r_ex_result  <= w_ex_result;
            r_mem_wdata  <= w_store;
            r_pc         <= i_pc;
            r_pc_plus4   <= i_pc_plus4;
            r_rd         <= i_rd_in;
            r_result_src <= i_result_src_in;
            if (o_ex_stall || w_kill) begin
                r_valid     <= 1'b0;
                r_reg_write <= 1'b0;
                r_mem_write <= 1'b0;
            end else begin
                r_valid     <= i_id_valid;
                r_reg_write <= i_reg_write_in;
                r_mem_write <= i_mem_write_in;
            end
        end
    end

    assign o_ex_result_m  = r_ex_result;
    assign o_mem_wdata_m  = r_mem_wdata;
    assign o_pc_m         = r_pc;
    assign o_pc_plus4_m   = r_pc_plus4;
    assign o_rd_m         = r_rd;
    assign o_reg_write_m  = r_reg_write;
    assign o_mem_write_m  = r_mem_write;
    assign o_valid_m      = r_valid;
    assign o_result_src_m = r_result_src;

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed plus randomized bench for execute_stage_md (XLEN = 32).
module tb_execute_stage_md;
    import execute_stage_md_pkg::*;

    logic        clk, reset;
    logic        id_valid, alu_src, md_en, reg_write_in, mem_write_in, mem_stall, md_kill;
    logic [31:0] rd1, rd2, pc, pc_plus4, imm, fwd_mem, fwd_wb;
    logic [3:0]  alu_ctrl;
    logic [2:0]  md_op, result_src_in;
    logic [1:0]  store_src, fwd_a_sel, fwd_b_sel;
    logic [4:0]  rd_in;
    logic        ex_stall, md_busy, reg_write_m, mem_write_m, valid_m;
    logic [31:0] pc_target, ex_result_m, mem_wdata_m, pc_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [2:0]  result_src_m;

    int total = 0;
    int bad   = 0;

    execute_stage_md #(.XLEN(32), .MD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .i_id_valid(id_valid), .i_rd1(rd1), .i_rd2(rd2),
        .i_pc(pc), .i_pc_plus4(pc_plus4), .i_imm(imm), .i_alu_ctrl(alu_ctrl),
        .i_alu_src(alu_src), .i_md_en(md_en), .i_md_op(md_op), .i_store_src(store_src),
        .i_fwd_a_sel(fwd_a_sel), .i_fwd_b_sel(fwd_b_sel), .i_fwd_mem(fwd_mem),
        .i_fwd_wb(fwd_wb), .i_rd_in(rd_in), .i_reg_write_in(reg_write_in),
        .i_mem_write_in(mem_write_in), .i_result_src_in(result_src_in),
        .i_mem_stall(mem_stall), .i_md_kill(md_kill), .o_ex_stall(ex_stall),
        .o_md_busy(md_busy), .o_pc_target(pc_target), .o_ex_result_m(ex_result_m),
        .o_mem_wdata_m(mem_wdata_m), .o_pc_m(pc_m), .o_pc_plus4_m(pc_plus4_m),
        .o_rd_m(rd_m), .o_reg_write_m(reg_write_m), .o_mem_write_m(mem_write_m),
        .o_valid_m(valid_m), .o_result_src_m(result_src_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        id_valid = 0; rd1 = 0; rd2 = 0; pc = 0; pc_plus4 = 0; imm = 0;
        alu_ctrl = ALU_ADD; alu_src = 0; md_en = 0; md_op = 0; store_src = ST_ZERO;
        fwd_a_sel = FWD_REG; fwd_b_sel = FWD_REG; fwd_mem = 0; fwd_wb = 0;
        rd_in = 0; reg_write_in = 0; mem_write_in = 0; result_src_in = 0;
        mem_stall = 0; md_kill = 0;
    endtask

    // Reference ALU straight from the operation names
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << b[4:0];
            4'd8:  return a >> b[4:0];
            4'd9:  return $unsigned($signed(a) >>> b[4:0]);
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r, input logic [31:0] m, input logic [31:0] w);
        return (sel == 2'd0) ? r : (sel == 2'd1) ? m : (sel == 2'd2) ? w : 32'd0;
    endfunction

    // Reference M-extension using full-width 64-bit arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        logic [31:0] q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue an M op, check its stall length, bubble and final writeback
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        set_nop();
        id_valid = 1; md_en = 1; md_op = op; rd1 = a; rd2 = b;
        rd_in = 5'd9; reg_write_in = 1; pc = 32'h200; pc_plus4 = 32'h204;
        #1;
        n = 0;
        while (ex_stall === 1'b1 && n < 200) begin
            step();
            n++;
            if (n == 1) chk({tag, "_bubble"}, {63'd0, valid_m}, 64'd0);
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
        step();
        chk(tag, {32'd0, ex_result_m}, {32'd0, exp});
        chk({tag, "_valid"}, {63'd0, valid_m}, 64'd1);
        set_nop();
    endtask

    initial begin
        logic [31:0] a, b, bb, exp_st;
        logic [2:0]  op;
        int n;

        set_nop();
        reset = 1;
        #12;
        chk("reset_result", {32'd0, ex_result_m}, 64'd0);
        chk("reset_ctrl", {52'd0, valid_m, reg_write_m, mem_write_m, md_busy, rd_m, result_src_m}, 64'd0);
        reset = 0;
        step();

        // ADD with immediate
        id_valid = 1; rd1 = 5; imm = 7; alu_src = 1; alu_ctrl = ALU_ADD;
        rd_in = 5'd3; reg_write_in = 1; result_src_in = 3'd1; pc = 32'h100; pc_plus4 = 32'h104;
        #1;
        chk("add_no_stall", {63'd0, ex_stall}, 64'd0);
        chk("pc_target", {32'd0, pc_target}, 64'h107);
        step();
        chk("add_result", {32'd0, ex_result_m}, 64'd12);
        chk("add_valid", {63'd0, valid_m}, 64'd1);
        chk("add_ctrl", {52'd0, rd_m, reg_write_m, result_src_m}, {52'd0, 5'd3, 1'b1, 3'd1});
        chk("add_pcs", {pc_m, pc_plus4_m}, {32'h100, 32'h104});

        // Memory stall freezes EX/MEM
        rd1 = 50; mem_stall = 1;
        #1;
        chk("memstall_ex_stall", {63'd0, ex_stall}, 64'd1);
        step();
        chk("memstall_hold", {32'd0, ex_result_m}, 64'd12);
        mem_stall = 0;
        step();
        chk("memstall_release", {32'd0, ex_result_m}, 64'd57);

        // Forwarding from MEM into A, SUB
        set_nop();
        id_valid = 1; fwd_a_sel = FWD_MEM; fwd_mem = 100; rd2 = 1; alu_ctrl = ALU_SUB;
        step();
        chk("fwd_sub", {32'd0, ex_result_m}, 64'd99);

        // Store byte sign extension
        set_nop();
        id_valid = 1; rd2 = 32'h1234_5680; store_src = ST_SB; mem_write_in = 1;
        step();
        chk("sb_wdata", {32'd0, mem_wdata_m}, 64'hFFFF_FF80);
        chk("sb_mem_write", {63'd0, mem_write_m}, 64'd1);

        // Randomized single-cycle ops
        for (int i = 0; i < 24; i++) begin
            set_nop();
            id_valid = 1'($urandom_range(0, 1));
            alu_ctrl = 4'($urandom_range(0, 10));
            rd1 = $urandom; rd2 = $urandom; imm = $urandom; fwd_mem = $urandom; fwd_wb = $urandom;
            pc = $urandom; pc_plus4 = pc + 4;
            alu_src = 1'($urandom_range(0, 1));
            fwd_a_sel = 2'($urandom_range(0, 3));
            fwd_b_sel = 2'($urandom_range(0, 3));
            store_src = 2'($urandom_range(0, 3));
            a  = ref_fwd(fwd_a_sel, rd1, fwd_mem, fwd_wb);
            bb = ref_fwd(fwd_b_sel, rd2, fwd_mem, fwd_wb);
            b  = alu_src ? imm : bb;
            case (store_src)
                2'd0: exp_st = {{24{bb[7]}}, bb[7:0]};
                2'd1: exp_st = {{16{bb[15]}}, bb[15:0]};
                2'd2: exp_st = bb;
                default: exp_st = 32'd0;
            endcase
            #1;
            chk("rnd_pc_target", {32'd0, pc_target}, {32'd0, pc + imm});
            step();
            chk("rnd_alu", {32'd0, ex_result_m}, {32'd0, ref_alu(alu_ctrl, a, b)});
            chk("rnd_store", {32'd0, mem_wdata_m}, {32'd0, exp_st});
            chk("rnd_valid", {63'd0, valid_m}, {63'd0, id_valid});
        end

        // Directed M ops
        run_md("mul",   MD_MUL,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE);
        run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_md("divu_z",  MD_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_md("remu_z",  MD_REMU, 32'd9, 32'd0, 32'd9);

        // Randomized M ops against the reference model
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_md("rnd_md", op, a, b, ref_md(op, a, b));
        end

        // Memory stall while the M result is ready
        set_nop();
        id_valid = 1; md_en = 1; md_op = MD_MUL; rd1 = 7; rd2 = 6; reg_write_in = 1;
        #1;
        n = 0;
        while (ex_stall === 1'b1 && n < 200) begin step(); n++; end
        mem_stall = 1;
        #1;
        chk("done_hold_stall", {63'd0, ex_stall}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done_hold_busy", {63'd0, md_busy}, 64'd1);
            chk("done_hold_valid", {63'd0, valid_m}, 64'd0);
        end
        mem_stall = 0;
        #1;
        chk("done_release_stall", {63'd0, ex_stall}, 64'd0);
        step();
        chk("done_release_result", {32'd0, ex_result_m}, 64'd42);
        chk("done_release_valid", {63'd0, valid_m}, 64'd1);
        chk("done_release_idle", {63'd0, md_busy}, 64'd0);

        // Kill at BUSY cycle 10
        set_nop();
        id_valid = 1; md_en = 1; md_op = MD_DIV; rd1 = 1000; rd2 = 7; reg_write_in = 1;
        for (int i = 0; i < 11; i++) step();
        chk("kill_pre_busy", {63'd0, md_busy}, 64'd1);
        md_kill = 1; id_valid = 0;
        step();
        md_kill = 0;
        chk("kill_idle", {63'd0, md_busy}, 64'd0);
        chk("kill_no_wb", {63'd0, valid_m & reg_write_m}, 64'd0);
        step();
        chk("kill_no_wb_later", {63'd0, valid_m}, 64'd0);

        // Asynchronous reset five cycles into an M op
        set_nop();
        id_valid = 1; md_en = 1; md_op = MD_MUL; rd1 = 3; rd2 = 4; pc = 32'h300;
        for (int i = 0; i < 5; i++) step();
        reset = 1;
        #1;
        chk("rst_mid_busy", {63'd0, md_busy}, 64'd0);
        chk("rst_mid_data", {ex_result_m, pc_m}, 64'd0);
        chk("rst_mid_data2", {mem_wdata_m, pc_plus4_m}, 64'd0);
        chk("rst_mid_ctrl", {53'd0, valid_m, reg_write_m, mem_write_m, rd_m, result_src_m}, 64'd0);
        set_nop();
        #2;
        reset = 0;
        step();
        run_md("post_rst_mul", MD_MUL, 32'd3, 32'd4, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
